// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch controller state encoding and shared constants
package fetch_pkg;
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_REDIR} fetch_state_t;
  localparam int INSTR_W = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC owner, single-outstanding imem reader, instruction hold for decode, wrong-path squash
//   clk/reset           rising-edge clock, synchronous active-low reset
//   pc_out/next_pc      fetch PC to incrementer, incrementer result taken on sig_recvd
//   sig_recvd           pulse asking the incrementer to advance or redirect
//   is_jmp/fetch_flush  redirect triggers, squash any in-flight or held fetch
//   imem_req_*          read request (valid/ready/addr)
//   imem_resp_*         read response, one per accepted request
//   if_valid/if_instr/if_pc/id_ready  instruction handoff to decode
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [XLEN-1:0]    pc_out,
  input  logic [XLEN-1:0]    next_pc,
  output logic               sig_recvd,
  input  logic               is_jmp,
  input  logic               fetch_flush,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  input  logic               id_ready
);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, if_pc_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic redir;
  assign pc_out        = pc_q;
  assign imem_req_addr = pc_q;
  assign if_instr      = if_instr_q;
  assign if_pc         = if_pc_q;
  // Request stays asserted in S_REQ during a redirect; if ready is low it is simply never handshaken.
  always_comb begin
    redir          = is_jmp | fetch_flush;
    imem_req_valid = reset && state_q == S_REQ;
    if_valid       = reset && state_q == S_HOLD && !redir;
    sig_recvd      = reset && !redir && ((state_q == S_HOLD && id_ready) || state_q == S_REDIR);
    state_d        = state_q;
    unique case (state_q)
      S_REQ:   state_d = redir ? (imem_req_ready ? S_DRAIN : S_REDIR) : (imem_req_ready ? S_WAIT : S_REQ);
      S_WAIT:  state_d = imem_resp_valid ? (redir ? S_REDIR : S_HOLD) : (redir ? S_DRAIN : S_WAIT);
      S_HOLD:  state_d = redir ? S_REDIR : (id_ready ? S_REQ : S_HOLD);
      S_DRAIN: state_d = imem_resp_valid ? S_REDIR : S_DRAIN;
      S_REDIR: state_d = redir ? S_REDIR : S_REQ;
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (sig_recvd) pc_q <= next_pc;
      if (state_q == S_WAIT && imem_resp_valid && !redir) begin
        if_instr_q <= imem_resp_data;
        if_pc_q    <= pc_q;
      end
    end
  end
  // A response with nothing outstanding means the memory broke the one-response-per-request rule.
  assert property (@(posedge clk) disable iff (!reset)
    !(imem_resp_valid && (state_q == S_REQ || state_q == S_HOLD)));
endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;
  localparam int XLEN = 64;
  localparam logic [63:0] RPC = 64'h1000;
  logic clk = 0, reset = 0;
  logic [XLEN-1:0] pc_out, next_pc, imem_req_addr, if_pc;
  logic sig_recvd, is_jmp = 0, fetch_flush = 0;
  logic imem_req_valid, imem_req_ready = 1, imem_resp_valid = 0, if_valid, id_ready = 1;
  logic [31:0] imem_resp_data = '0, if_instr;
  typedef struct {logic [63:0] pc; logic [31:0] instr;} exp_t;
  exp_t exp_q[$];
  logic [63:0] acc_q[$];
  int acc_cyc[$];
  int checks = 0, errors = 0, cyc_n = 0, sig_cnt = 0, k = 1, cnt = 0, s0;
  bit pend = 0, tgt_v = 0;
  logic [63:0] pend_addr = '0, tgt = '0;

  fetch_ctrl #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .next_pc(next_pc), .sig_recvd(sig_recvd),
    .is_jmp(is_jmp), .fetch_flush(fetch_flush), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready));

  always #5 clk = ~clk;
  assign next_pc = tgt_v ? tgt : pc_out + 64'd4;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    bit acc, sig_seen, redir;
    #2;
    redir = is_jmp | fetch_flush;
    acc = imem_req_valid && imem_req_ready;
    sig_seen = sig_recvd;
    if (redir) chk("no_sig_on_redir", sig_recvd, 0);
    if (sig_recvd) sig_cnt++;
    if (acc) begin
      exp_q.push_back('{imem_req_addr, mem_word(imem_req_addr)});
      acc_q.push_back(imem_req_addr);
      acc_cyc.push_back(cyc_n);
    end
    if (if_valid === 1'b1) begin
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("if_pc", if_pc, exp_q[0].pc);
        chk("if_instr", if_instr, exp_q[0].instr);
        if (id_ready) void'(exp_q.pop_front());
      end
    end
    if (redir || !reset) exp_q.delete();
    @(posedge clk);
    #1;
    cyc_n++;
    if (sig_seen) tgt_v = 0;
    if (acc) begin pend = 1; cnt = k; pend_addr = imem_req_addr; end
    if (!reset) pend = 0;
    imem_resp_valid = 0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin imem_resp_valid = 1; imem_resp_data = mem_word(pend_addr); pend = 0; end
    end
  endtask

  initial begin
    // reset
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_sig", sig_recvd, 0);
    cyc(); cyc();
    chk("rst_pc", pc_out, RPC);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    reset = 1;
    acc_q.delete(); acc_cyc.delete(); sig_cnt = 0;
    // streaming, k=1, decode always ready
    for (int i = 0; i < 9; i++) cyc();
    chk("stream_acc_n", acc_q.size(), 3);
    if (acc_q.size() >= 3) begin
      chk("stream_a0", acc_q[0], 64'h1000);
      chk("stream_a1", acc_q[1], 64'h1004);
      chk("stream_a2", acc_q[2], 64'h1008);
      chk("cadence01", acc_cyc[1] - acc_cyc[0], 3);
      chk("cadence12", acc_cyc[2] - acc_cyc[1], 3);
    end
    chk("stream_sig_n", sig_cnt, 3);
    chk("stream_pc", pc_out, 64'h100C);
    // memory back-pressure
    imem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid", imem_req_valid, 1);
      chk("bp_addr", imem_req_addr, 64'h100C);
      cyc();
    end
    imem_req_ready = 1;
    id_ready = 0;
    cyc(); cyc();
    chk("bp_acc_n", acc_q.size(), 4);
    chk("bp_acc_addr", acc_q[acc_q.size()-1], 64'h100C);
    // decode stall in S_HOLD
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_if_valid", if_valid, 1);
      chk("stall_if_pc", if_pc, 64'h100C);
      chk("stall_if_instr", if_instr, mem_word(64'h100C));
      chk("stall_sig", sig_recvd, 0);
      chk("stall_req", imem_req_valid, 0);
      cyc();
    end
    id_ready = 1;
    cyc();
    chk("stall_sig_n", sig_cnt, 4);
    chk("stall_pc", pc_out, 64'h1010);
    // jump while a k=3 request is outstanding
    k = 3;
    cyc();
    is_jmp = 1; tgt = 64'h2000; tgt_v = 1;
    cyc();
    is_jmp = 0;
    s0 = sig_cnt;
    for (int i = 0; i < 10 && sig_cnt == s0; i++) cyc();
    chk("jmp_sig_once", sig_cnt, s0 + 1);
    chk("jmp_sb_empty", exp_q.size(), 0);
    #1;
    chk("jmp_req_valid", imem_req_valid, 1);
    chk("jmp_req_addr", imem_req_addr, 64'h2000);
    // flush in S_HOLD with decode ready
    k = 1;
    cyc(); cyc();
    fetch_flush = 1; tgt = 64'h3000; tgt_v = 1;
    #1;
    chk("flush_sig", sig_recvd, 0);
    chk("flush_if_valid", if_valid, 0);
    cyc();
    fetch_flush = 0;
    #1;
    chk("flush_redir_sig", sig_recvd, 1);
    chk("flush_redir_req", imem_req_valid, 0);
    cyc();
    #1;
    chk("flush_req_valid", imem_req_valid, 1);
    chk("flush_req_addr", imem_req_addr, 64'h3000);
    // reset while waiting for a response
    k = 3;
    cyc();
    reset = 0;
    #1;
    chk("mid_rst_req", imem_req_valid, 0);
    chk("mid_rst_if_valid", if_valid, 0);
    chk("mid_rst_sig", sig_recvd, 0);
    cyc();
    chk("mid_rst_pc", pc_out, RPC);
    chk("mid_rst_if_pc", if_pc, 0);
    chk("mid_rst_if_instr", if_instr, 0);
    reset = 1;
    #1;
    chk("post_rst_valid", imem_req_valid, 1);
    chk("post_rst_addr", imem_req_addr, RPC);
    k = 1;
    s0 = sig_cnt;
    cyc(); cyc(); cyc();
    chk("post_rst_sig_n", sig_cnt, s0 + 1);
    chk("post_rst_pc", pc_out, RPC + 64'd4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
